// File: rtl/read_master_if.sv
// Signal bundle for read_master: Avalon-MM DDR read port, 16-bit CSR slave and sample stream.
// The master modport is the read_master side; the slave modport is the DDR/host/sink side.
interface read_master_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] ddr_addr;
  logic              ddr_read;
  logic              ddr_waitrequest;
  logic [15:0]       ddr_readdata;
  logic              ddr_readdatavalid;
  logic [2:0]        addr;
  logic              read;
  logic              write;
  logic [15:0]       writedata;
  logic [15:0]       readdata;
  logic [15:0]       d_out;
  logic              d_out_valid;
  logic              d_out_ready;

  modport master (
    output ddr_addr, ddr_read,
    input  ddr_waitrequest, ddr_readdata, ddr_readdatavalid,
    input  addr, read, write, writedata,
    output readdata,
    output d_out, d_out_valid,
    input  d_out_ready
  );

  modport slave (
    input  ddr_addr, ddr_read,
    output ddr_waitrequest, ddr_readdata, ddr_readdatavalid,
    output addr, read, write, writedata,
    input  readdata,
    input  d_out, d_out_valid,
    output d_out_ready
  );
endinterface

// File: rtl/read_master.sv
// Credit-limited pipelined Avalon-MM read master: fetches a block of 16-bit samples from DDR,
// buffers responses in a FIFO and streams them out over valid/ready.
module read_master #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic          clk,
  input  logic          rst,
  read_master_if.master bus_io
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned SumW = CntW + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [31:0]       base_q, base_d;
  logic [15:0]       length_q, length_d;
  logic [15:0]       step_q, step_d;
  logic [ADDR_W-1:0] ddr_addr_q, ddr_addr_d;
  logic              ddr_read_q, ddr_read_d;
  logic [15:0]       issued_q, issued_d;
  logic [CntW-1:0]   outst_q, outst_d;
  logic [CntW-1:0]   discard_q, discard_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [15:0]       readdata_q, readdata_d;
  logic [15:0]       mem_q [FIFO_DEPTH];

  logic            cfg_ok, cmd_wr, soft_rst, start;
  logic            accept, rdv, push, pop, busy, done;
  logic [CntW-1:0] pend;
  logic [SumW-1:0] credit_sum;

  assign busy     = (state_q == StRun) || (state_q == StDrain);
  assign done     = (state_q == StDone);
  assign cfg_ok   = (state_q == StIdle) || (state_q == StDone);
  assign cmd_wr   = bus_io.write && (bus_io.addr == 3'd4);
  assign soft_rst = cmd_wr && bus_io.writedata[1];
  // A start is held off while responses from an abandoned block are still in flight.
  assign start    = cmd_wr && bus_io.writedata[0] && !bus_io.writedata[1] && cfg_ok &&
                    (discard_q == '0);
  assign accept   = ddr_read_q && !bus_io.ddr_waitrequest;
  assign rdv      = bus_io.ddr_readdatavalid;
  assign push     = rdv && (discard_q == '0) && !soft_rst;
  assign pop      = (count_q != '0) && bus_io.d_out_ready;
  assign pend     = discard_q + outst_q + CntW'(accept);

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    length_d   = length_q;
    step_d     = step_q;
    ddr_addr_d = ddr_addr_q;
    ddr_read_d = 1'b0;
    issued_d   = issued_q + 16'(accept);
    outst_d    = outst_q + CntW'(accept) - CntW'(push);
    discard_d  = discard_q;
    count_d    = count_q + CntW'(push) - CntW'(pop);
    wr_ptr_d   = wr_ptr_q + PtrW'(push);
    rd_ptr_d   = rd_ptr_q + PtrW'(pop);
    readdata_d = '0;
    credit_sum = '0;

    if (accept) begin
      ddr_addr_d = ddr_addr_q + ADDR_W'(step_q);
    end
    if (rdv && (discard_q != '0)) begin
      discard_d = discard_q - CntW'(1);
    end

    if (bus_io.read) begin
      case (bus_io.addr)
        3'd0:    readdata_d = base_q[15:0];
        3'd1:    readdata_d = base_q[31:16];
        3'd2:    readdata_d = length_q;
        3'd3:    readdata_d = step_q;
        3'd4:    readdata_d = 16'h0000;
        3'd5:    readdata_d = {14'b0, busy, done};
        default: readdata_d = 16'hDEAD;
      endcase
    end

    if (bus_io.write && cfg_ok) begin
      case (bus_io.addr)
        3'd0:    base_d[15:0]  = bus_io.writedata;
        3'd1:    base_d[31:16] = bus_io.writedata;
        3'd2:    length_d      = bus_io.writedata;
        3'd3:    step_d        = bus_io.writedata;
        default: ;
      endcase
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StRun;
          ddr_addr_d = ADDR_W'(base_q);
          issued_d   = '0;
          outst_d    = '0;
        end
      end
      StRun: begin
        if (issued_d == length_q) state_d = StDrain;
      end
      StDrain: begin
        if ((outst_q == '0) && (count_q == '0)) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase

    // Outstanding reads plus buffered samples never exceed the FIFO, so a push never overflows.
    credit_sum = SumW'(outst_d) + SumW'(count_d);
    if (ddr_read_q && !accept) begin
      ddr_read_d = 1'b1;
    end else begin
      ddr_read_d = (state_d == StRun) && (issued_d < length_q) &&
                   (credit_sum < SumW'(FIFO_DEPTH));
    end

    if (soft_rst) begin
      state_d    = StIdle;
      base_d     = '0;
      length_d   = '0;
      step_d     = 16'd1;
      ddr_addr_d = '0;
      ddr_read_d = 1'b0;
      issued_d   = '0;
      outst_d    = '0;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      // Every read the slave has accepted (including one accepted this cycle) still answers.
      discard_d  = (rdv && (pend != '0)) ? pend - CntW'(1) : pend;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      base_q     <= '0;
      length_q   <= '0;
      step_q     <= 16'd1;
      ddr_addr_q <= '0;
      ddr_read_q <= 1'b0;
      issued_q   <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      length_q   <= length_d;
      step_q     <= step_d;
      ddr_addr_q <= ddr_addr_d;
      ddr_read_q <= ddr_read_d;
      issued_q   <= issued_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      readdata_q <= readdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus_io.ddr_readdata;
  end

  assign bus_io.ddr_addr    = ddr_addr_q;
  assign bus_io.ddr_read    = ddr_read_q;
  assign bus_io.readdata    = readdata_q;
  assign bus_io.d_out_valid = (count_q != '0);
  assign bus_io.d_out       = (count_q != '0) ? mem_q[rd_ptr_q] : 16'h0000;
endmodule

// File: tb/tb_read_master.sv
// Randomized bench for read_master: DDR slave and stream sink models at negedge, expected
// address/sample sequences computed as base + i*step.
module tb_read_master;
  localparam int unsigned Depth = 16;
  localparam int unsigned AW    = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  read_master_if #(.ADDR_W(AW)) bus ();
  read_master #(.FIFO_DEPTH(Depth), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus_io(bus));

  int checks = 0;
  int errors = 0;

  int unsigned cyc = 0;
  int unsigned wait_pct, lat_max, last_due;
  int          max_acc, max_resp, stall_idx, stall_left, ready_mode;
  bit          hold_chk_en;
  int          hold_errs, acc_cnt, resp_cnt, read_seen;
  logic [31:0] acc_log[$];
  int unsigned resp_due[$];
  logic [15:0] resp_dat[$];
  logic [15:0] got[$];
  logic        prev_req, prev_wait, w, rdy;
  logic [31:0] prev_addr;
  int unsigned due;

  // DDR slave and sink: decide this cycle's inputs and record transfers at the coming posedge.
  always @(negedge clk) begin
    if (rst) begin
      resp_due.delete();
      resp_dat.delete();
      bus.ddr_waitrequest   = 1'b0;
      bus.ddr_readdatavalid = 1'b0;
      bus.ddr_readdata      = '0;
      bus.d_out_ready       = 1'b0;
      prev_req = 1'b0;
      prev_wait = 1'b0;
      last_due = 0;
    end else begin
      cyc++;
      if (hold_chk_en && prev_req && prev_wait &&
          (bus.ddr_read !== 1'b1 || bus.ddr_addr !== prev_addr)) hold_errs++;
      if (bus.ddr_read) read_seen++;
      w = (wait_pct != 0) && ($urandom_range(99, 0) < wait_pct);
      if (acc_cnt >= max_acc) w = 1'b1;
      if (bus.ddr_read && acc_cnt == stall_idx && stall_left > 0) begin
        w = 1'b1;
        stall_left--;
      end
      bus.ddr_waitrequest = w;
      if (bus.ddr_read && !w) begin
        acc_log.push_back(bus.ddr_addr);
        acc_cnt++;
        due = cyc + $urandom_range(lat_max, 1);
        if (due < last_due) due = last_due;
        last_due = due;
        resp_due.push_back(due);
        resp_dat.push_back(bus.ddr_addr[15:0]);
      end
      if (resp_due.size() > 0 && resp_due[0] <= cyc && resp_cnt < max_resp) begin
        bus.ddr_readdatavalid = 1'b1;
        bus.ddr_readdata      = resp_dat.pop_front();
        void'(resp_due.pop_front());
        resp_cnt++;
      end else begin
        bus.ddr_readdatavalid = 1'b0;
        bus.ddr_readdata      = 16'($urandom);
      end
      case (ready_mode)
        0:       rdy = 1'b0;
        1:       rdy = 1'b1;
        default: rdy = 1'($urandom_range(1, 0));
      endcase
      bus.d_out_ready = rdy;
      if (bus.d_out_valid && rdy) got.push_back(bus.d_out);
      prev_req  = bus.ddr_read;
      prev_wait = w;
      prev_addr = bus.ddr_addr;
    end
  end

  task automatic set_defaults();
    wait_pct = 0; lat_max = 1; max_acc = 1 << 30; max_resp = 1 << 30;
    stall_idx = -1; stall_left = 0; ready_mode = 1; hold_chk_en = 1'b1;
  endtask

  task automatic clear_logs();
    acc_log.delete(); got.delete();
    acc_cnt = 0; resp_cnt = 0; read_seen = 0; hold_errs = 0;
  endtask

  task automatic csr_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.addr = a; bus.writedata = d; bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
  endtask

  task automatic csr_read(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    bus.addr = a; bus.read = 1'b1;
    @(negedge clk);
    bus.read = 1'b0;
    d = bus.readdata;
  endtask

  task automatic start_run(input logic [31:0] base, input logic [15:0] len,
                           input logic [15:0] step);
    clear_logs();
    csr_write(3'd0, base[15:0]);
    csr_write(3'd1, base[31:16]);
    csr_write(3'd2, len);
    csr_write(3'd3, step);
    csr_write(3'd4, 16'h0001);
  endtask

  task automatic wait_done(input int max_polls, output bit ok, output int polls);
    logic [15:0] s;
    ok = 1'b0; polls = 0;
    while (!ok && polls < max_polls) begin
      csr_read(3'd5, s);
      polls++;
      if (s == 16'h0001) ok = 1'b1;
    end
  endtask

  task automatic finish_check(input string name, input logic [31:0] base,
                              input logic [15:0] len, input logic [15:0] step);
    bit ok;
    int polls;
    logic [31:0] ea;
    wait_done(3000, ok, polls);
    checks++;
    if (!ok) begin errors++; $display("FAIL %s done: status never 0x1 after %0d polls", name, polls); end
    checks++;
    if (acc_cnt !== int'(len)) begin
      errors++; $display("FAIL %s accepts: got %0d expected %0d", name, acc_cnt, len);
    end
    checks++;
    if (got.size() !== int'(len)) begin
      errors++; $display("FAIL %s samples: got %0d expected %0d", name, got.size(), len);
    end
    for (int i = 0; i < int'(len); i++) begin
      ea = base + 32'(i) * 32'(step);
      if (i < acc_log.size()) begin
        checks++;
        if (acc_log[i] !== ea) begin
          errors++; $display("FAIL %s addr[%0d]: got %h expected %h", name, i, acc_log[i], ea);
        end
      end
      if (i < got.size()) begin
        checks++;
        if (got[i] !== ea[15:0]) begin
          errors++; $display("FAIL %s d_out[%0d]: got %h expected %h", name, i, got[i], ea[15:0]);
        end
      end
    end
    checks++;
    if (hold_errs !== 0) begin
      errors++; $display("FAIL %s hold: %0d unstable stalled requests, expected 0", name, hold_errs);
    end
  endtask

  task automatic test_reset();
    logic [15:0] d;
    logic [2:0]  a [7];
    logic [15:0] e [7];
    a = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
    e = '{16'h0, 16'h0, 16'h0, 16'h1, 16'h0, 16'hDEAD, 16'hDEAD};
    checks++;
    if ({bus.ddr_read, bus.d_out_valid, bus.d_out, bus.readdata, bus.ddr_addr} !== '0) begin
      errors++;
      $display("FAIL reset outputs: read=%b valid=%b d_out=%h rd=%h addr=%h expected all 0",
               bus.ddr_read, bus.d_out_valid, bus.d_out, bus.readdata, bus.ddr_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      csr_read(a[i], d);
      checks++;
      if (d !== e[i]) begin
        errors++; $display("FAIL reset csr[%0d]: got %h expected %h", a[i], d, e[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.readdata !== 16'h0) begin
      errors++; $display("FAIL readdata idle: got %h expected 0000", bus.readdata);
    end
  endtask

  task automatic test_basic();
    logic [15:0] s;
    set_defaults();
    start_run(32'h0000_1000, 16'd4, 16'd2);
    finish_check("basic", 32'h0000_1000, 16'd4, 16'd2);
    csr_read(3'd5, s);
    checks++;
    if (s !== 16'h0001) begin errors++; $display("FAIL basic status: got %h expected 0001", s); end
  endtask

  task automatic test_waitrequest();
    set_defaults();
    stall_idx = 1; stall_left = 3;
    start_run(32'h0000_1000, 16'd4, 16'd2);
    finish_check("waitreq", 32'h0000_1000, 16'd4, 16'd2);
    checks++;
    if (read_seen !== 7) begin
      errors++; $display("FAIL waitreq read cycles: got %0d expected 7", read_seen);
    end
    checks++;
    if (stall_left !== 0) begin
      errors++; $display("FAIL waitreq stall: %0d stall cycles unused, expected 0", stall_left);
    end
  endtask

  task automatic test_credit();
    logic [15:0] s;
    set_defaults();
    ready_mode = 0; lat_max = 3;
    start_run(32'h0000_2000, 16'd40, 16'd1);
    repeat (100) @(negedge clk);
    checks++;
    if (acc_cnt !== int'(Depth)) begin
      errors++; $display("FAIL credit accepts: got %0d expected %0d", acc_cnt, Depth);
    end
    checks++;
    if (bus.ddr_read !== 1'b0) begin
      errors++; $display("FAIL credit ddr_read: got %b expected 0", bus.ddr_read);
    end
    csr_read(3'd5, s);
    checks++;
    if (s !== 16'h0002) begin errors++; $display("FAIL credit status: got %h expected 0002", s); end
    ready_mode = 2;
    finish_check("credit", 32'h0000_2000, 16'd40, 16'd1);
  endtask

  task automatic test_zero_len();
    bit ok;
    int polls;
    set_defaults();
    start_run(32'h0000_5000, 16'd0, 16'd1);
    wait_done(2, ok, polls);
    checks++;
    if (!ok) begin errors++; $display("FAIL zero_len done: not done after %0d polls, expected done", polls); end
    checks++;
    if (read_seen !== 0) begin
      errors++; $display("FAIL zero_len ddr_read: high %0d cycles expected 0", read_seen);
    end
  endtask

  task automatic test_wrap();
    set_defaults();
    wait_pct = 30; lat_max = 4; ready_mode = 2;
    start_run(32'hFFFF_FFFE, 16'd4, 16'd1);
    finish_check("wrap", 32'hFFFF_FFFE, 16'd4, 16'd1);
    checks++;
    if (acc_log.size() > 2 && acc_log[2] !== 32'h0) begin
      errors++; $display("FAIL wrap addr2: got %h expected 00000000", acc_log[2]);
    end
  endtask

  task automatic test_random();
    logic [31:0] b;
    logic [15:0] l, s;
    for (int n = 0; n < 5; n++) begin
      set_defaults();
      wait_pct = $urandom_range(50, 0); lat_max = $urandom_range(6, 1); ready_mode = 2;
      b = $urandom;
      l = 16'($urandom_range(60, 1));
      s = 16'($urandom_range(500, 0));
      start_run(b, l, s);
      finish_check("random", b, l, s);
    end
  endtask

  task automatic test_soft_reset();
    logic [15:0] s;
    int t;
    set_defaults();
    hold_chk_en = 1'b0; max_acc = 5; max_resp = 2;
    start_run(32'h0000_3000, 16'd10, 16'd4);
    t = 0;
    while (!(acc_cnt == 5 && resp_cnt == 2 && got.size() == 2) && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 200) begin
      errors++; $display("FAIL soft pre: acc=%0d resp=%0d got=%0d expected 5/2/2", acc_cnt, resp_cnt, got.size());
    end
    checks++;
    if (resp_due.size() !== 3) begin
      errors++; $display("FAIL soft outstanding: got %0d expected 3", resp_due.size());
    end
    csr_write(3'd4, 16'h0003);
    read_seen = 0;
    checks++;
    if (bus.ddr_read !== 1'b0 || bus.d_out_valid !== 1'b0) begin
      errors++; $display("FAIL soft outputs: read=%b valid=%b expected 0 0", bus.ddr_read, bus.d_out_valid);
    end
    csr_write(3'd4, 16'h0001);
    repeat (10) @(negedge clk);
    csr_read(3'd5, s);
    checks++;
    if (s !== 16'h0000 || read_seen !== 0) begin
      errors++; $display("FAIL soft start blocked: status %h reads %0d expected 0000 0", s, read_seen);
    end
    max_resp = 1 << 30;
    repeat (12) @(negedge clk);
    checks++;
    if (resp_due.size() !== 0 || got.size() !== 2 || bus.d_out_valid !== 1'b0) begin
      errors++; $display("FAIL soft discard: pending %0d samples %0d valid %b expected 0 2 0",
                         resp_due.size(), got.size(), bus.d_out_valid);
    end
    checks++;
    if (got.size() == 2 && (got[0] !== 16'h3000 || got[1] !== 16'h3004)) begin
      errors++; $display("FAIL soft early samples: got %h %h expected 3000 3004", got[0], got[1]);
    end
    csr_read(3'd3, s);
    checks++;
    if (s !== 16'h0001) begin errors++; $display("FAIL soft step: got %h expected 0001", s); end
    max_acc = 1 << 30;
    start_run(32'h0000_4000, 16'd6, 16'd2);
    finish_check("soft fresh", 32'h0000_4000, 16'd6, 16'd2);
  endtask

  initial begin
    bus.addr = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
    set_defaults();
    clear_logs();
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_waitrequest();
    test_credit();
    test_zero_len();
    test_wrap();
    test_random();
    test_soft_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/read_master.md
Name: read_master

Overview:
- Avalon-MM read master that fetches a block of 16-bit signed samples from DDR3 and plays it out as a valid/ready sample stream (e.g. to DAC or demod datapath).
- Host configures base address, sample count and address step through a 16-bit CSR slave, then starts it.
- Pipelined reads; read responses are buffered in an internal FIFO; outstanding reads are credit-limited so the FIFO can never overflow.

Parameters:
- FIFO_DEPTH, 16, sample buffer depth (power of 2, >=2); also the cap on outstanding reads plus buffered samples.
- ADDR_W, 32, DDR address width.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- ddr_addr  out  ADDR_W  DDR read address.
- ddr_read  out  1  read request.
- ddr_waitrequest  in  1  slave stall; request held while high.
- ddr_readdata  in  16  read response data (signed sample).
- ddr_readdatavalid  in  1  response strobe, in-order, one per accepted read.
- addr  in  3  CSR word address.
- read  in  1  CSR read strobe.
- write  in  1  CSR write strobe.
- writedata  in  16  CSR write data.
- readdata  out  16  CSR read data.
- d_out  out  16  streamed sample (signed).
- d_out_valid  out  1  d_out holds a sample.
- d_out_ready  in  1  sink accepts sample.

Behaviour:
- Reset (rst, or soft reset): all outputs 0; base=0, length=0, step=1; FSM to IDLE; FIFO emptied.
- CSR map (writes in IDLE or DONE only; writes while busy ignored, except soft reset):
  - 0: base[15:0].
  - 1: base[31:16].
  - 2: length, samples, 16 bit.
  - 3: step, zero-extended.
  - 4: write bit0 = start, bit1 = soft reset. Soft reset wins if both bits are set.
  - 5: read-only status {14'b0, busy, done}.
- CSR reads: registered, 1-cycle latency. Unmapped addresses return 16'hDEAD. readdata = 0 in any cycle after a non-read.
- FSM:
  - IDLE: start -> RUN. Load ddr_addr = base; clear issued, outstanding and done.
  - RUN: issue reads (see credit below). When issued == length -> DRAIN.
  - DRAIN: when outstanding == 0 and FIFO empty -> DONE.
  - DONE: done = 1. start -> RUN, clearing done and reloading. Start in RUN/DRAIN is ignored.
- length = 0: start goes RUN -> DRAIN -> DONE with no ddr_read asserted.
- Credit rule: ddr_read may rise only when outstanding + fifo_count < FIFO_DEPTH and issued < length.
  - Once raised, ddr_read and ddr_addr hold stable until accepted (ddr_read && !ddr_waitrequest).
  - On acceptance: issued+1, outstanding+1, ddr_addr += step (modulo 2^ADDR_W, wraps silently).
  - Back-to-back accepts allowed, one per cycle.
- Response: ddr_readdatavalid pushes ddr_readdata into the FIFO and decrements outstanding.
  - Same-cycle accept and response: outstanding unchanged.
- Stream: d_out_valid = FIFO not empty; d_out = FIFO head.
  - Pop on d_out_valid && d_out_ready.
  - Push to an empty FIFO shows on d_out the next cycle (1-cycle latency).
  - Simultaneous push and pop at full or empty is legal.
- busy = state in RUN or DRAIN.
- Soft reset mid-operation:
  - FSM to IDLE, FIFO flushed, ddr_read dropped immediately. The in-flight handshake is abandoned and the DDR slave must tolerate this.
  - Remaining accepted responses are counted into a discard counter and dropped, never pushed.
  - A new start is ignored until the discard counter reaches 0.
- Async rst: everything cleared including the discard counter; the DDR side is reset together.

Test Plan:
- base=0x0000_1000, step=2, length=4, d_out_ready=1, zero-wait DDR returning addr[15:0] -> reads at 0x1000/0x1002/0x1004/0x1006, d_out 0x1000..0x1006 in order, status reads 0x1 after last sample.
- ddr_waitrequest high 3 cycles on second read -> ddr_addr=0x1002 and ddr_read held stable all 3 cycles; exactly 4 accepts total.
- FIFO_DEPTH=16, length=40, d_out_ready=0 -> exactly 16 reads accepted then ddr_read stays 0. Release ready -> all 40 samples delivered in order, none lost or duplicated.
- length=0 start -> no ddr_read; status=0x1 within 3 cycles.
- base=0xFFFF_FFFE, step=1, length=4 -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- Soft reset after 5 of 10 accepts with 3 outstanding -> those 3 responses dropped, d_out_valid=0; start blocked until discard counter is 0; the subsequent run delivers a correct fresh block.
